// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage MIPS pipeline sequencer; hold/flush controls for PC, IF/ID, ID/EX, EX/MEM, MEM/WB
//   inputs : decode operands (Rs_ID, Rt_ID, uses_rs, uses_rt), EX load info (Rt_EX, MemtoReg_EX, RegWrite_EX),
//            Jump_ID, branch_taken_EX, data-memory handshake (mem_req_MEM, mem_ready)
//   outputs: pc_en, *_stall load enables (1 = advance), *_clear flushes, sticky mem_err, saturating stall_cycles
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic             uses_rs,
  input  logic             uses_rt,
  input  logic [4:0]       Rt_EX,
  input  logic             MemtoReg_EX,
  input  logic             RegWrite_EX,
  input  logic             Jump_ID,
  input  logic             branch_taken_EX,
  input  logic             mem_req_MEM,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_stall,
  output logic             ifid_clear,
  output logic             idex_stall,
  output logic             idex_clear,
  output logic             exmem_stall,
  output logic             memwb_clear,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic mem_wait, freeze, load_use;
  assign mem_wait = mem_req_MEM & ~mem_ready;
  assign freeze   = mem_wait | (state_q == ERR);
  // register 0 is hardwired, so a load targeting it never creates a dependency
  assign load_use = MemtoReg_EX & RegWrite_EX & (Rt_EX != 5'd0) &
                    ((uses_rs & (Rs_ID == Rt_EX)) | (uses_rt & (Rt_ID == Rt_EX)));
  // a taken branch squashes the decode instruction, so it overrides the load-use hold
  assign pc_en       = ~freeze & (branch_taken_EX | ~load_use);
  assign ifid_stall  = pc_en;
  assign ifid_clear  = ~freeze & (branch_taken_EX | (~load_use & Jump_ID));
  assign idex_stall  = ~freeze;
  assign idex_clear  = ~freeze & (branch_taken_EX | load_use);
  assign exmem_stall = ~freeze;
  assign memwb_clear = freeze;
  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_cycles_q;
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    mem_err_d      = mem_err_q;
    stall_cycles_d = (~pc_en && stall_cycles_q != '1) ? stall_cycles_q + 1'b1 : stall_cycles_q;
    if (state_q == RUN && mem_wait) begin
      state_d    = MEM_WAIT;
      wait_cnt_d = CW'(1);
    end else if (state_q == MEM_WAIT) begin
      // a dropped request is treated the same as a completed access
      if (mem_ready || !mem_req_MEM) begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
        state_d   = ERR;
        mem_err_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      mem_err_q      <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_err_q      <= mem_err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
endmodule
